oh_stream_demux3: RTL
=====================

// Module: oh_stream_demux3
// PURPOSE
// - 1-to-3 valid/ready stream demultiplexer: the routing counterpart of the
//   3-input mux cell. Routes each input word to one of three output channels.
// - Select encoding matches the mux cell: s1=1 -> ch2; s1=0,s0=1 -> ch1;
//   s1=0,s0=0 -> ch0.
// - Each channel has a 2-entry buffer, so a stalled channel does not block
//   the others. in_ready has no combinational path from any out*_ready.
// PARAMETERS
// - DW    8          data width in bits
// - PROP  "DEFAULT"  implementation property, passed through and unused in RTL
// PORTS
// - clk        in   1   clock, all state updates on the rising edge
// - nreset     in   1   asynchronous active-low reset
// - in_valid   in   1   input word valid
// - in_data    in   DW  input word
// - in_s0      in   1   select bit 0, sampled with in_valid
// - in_s1      in   1   select bit 1, has priority over in_s0
// - in_ready   out  1   selected channel can accept the word this cycle
// - outN_valid out  1   channel N (N=0..2) has a word at its head
// - outN_data  out  DW  channel N head word
// - outN_ready in   1   channel N consumer accepts the head word
// BEHAVIOUR
// - Channel select: sel = in_s1 ? 2 : (in_s0 ? 1 : 0). Decoded combinationally.
// - in_ready = (cnt[sel] != 2). It depends only on registered count and the
//   select inputs. in_ready is valid even when in_valid=0.
// - Push on channel sel: in_valid & in_ready.
// - Pop on channel N: outN_valid & outN_ready.
// - Per-channel state cnt: EMPTY(0), ONE(1), FULL(2).
//   - EMPTY: push -> ONE.
//   - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE.
//   - FULL: pop -> ONE. No push is possible because in_ready=0. A same-cycle
//     pop does not raise in_ready until the next cycle.
// - Storage is two registers per channel: head and tail. outN_data = head.
//   - Push into EMPTY writes head.
//   - Push into ONE without a pop writes tail.
//   - Push into ONE with a simultaneous pop writes head.
//   - Pop from FULL moves tail to head.
// - outN_valid = (cnt != EMPTY).
// - Latency: a word pushed at edge k appears on outN_data/outN_valid after
//   edge k. Minimum latency is 1 cycle. Throughput is 1 word/cycle per
//   channel while its consumer keeps outN_ready=1.
// - Ordering: FIFO order is preserved per channel. There is no ordering
//   guarantee between channels.
// - Words are never dropped or duplicated. A pushed word is popped exactly once.
// - Unselected channels see no push. They pop independently in the same cycle.
// - Select bits change with in_valid=0: no effect on state.
// - Reset (async assert, any time, including mid-transfer):
//   - all cnt go to EMPTY, so outN_valid=0;
//   - head and tail go to 0, so outN_data=0;
//   - in_ready=1 while nreset=0.
//   - Deassertion takes effect at the next clk edge. In-flight words are
//     discarded.
// - Input stability: the upstream holds in_data, in_s0 and in_s1 stable while
//   in_valid=1 and in_ready=0.
// TESTING
// - Reset: drive nreset=0 mid-burst with ch1 FULL -> outN_valid=0 and
//   outN_data=0 immediately; in_ready=1 for every select.
// - Routing: send 0x11 (s1=0,s0=0), 0x22 (s0=1), 0x33 (s1=1), 0x44 (s1=1,s0=1)
//   with all ready=1 -> out0=0x11, out1=0x22, out2=0x33 then 0x44, each one
//   cycle after its push.
// - Backpressure: out0_ready=0, push 0xA1, 0xA2, 0xA3 to ch0 -> in_ready drops
//   after 2 pushes. Raise out0_ready -> 0xA1, 0xA2, 0xA3 delivered in order
//   with no loss.
// - Isolation: ch0 FULL and stalled, stream 16 words to ch2 -> all 16 accepted
//   at 1/cycle; ch0 contents unchanged.
// - Simultaneous push/pop at ONE: 1000 cycles random traffic, all ready=1 ->
//   cnt stays <=1, 1 word/cycle, scoreboard matches per channel.
// - Random: random valid/select/ready for 10k cycles -> per-channel scoreboard
//   matches exactly; the bench asserts in_ready==(cnt[sel]!=2) every cycle.

Source files
------------

// File: rtl/oh_stream_demux3_if.sv
// Handshake bundle for the 1-to-3 stream demux: one input stream, three output channels.
interface oh_stream_demux3_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_s0;
  logic          in_s1;
  logic          in_ready;
  logic          out0_valid;
  logic [DW-1:0] out0_data;
  logic          out0_ready;
  logic          out1_valid;
  logic [DW-1:0] out1_data;
  logic          out1_ready;
  logic          out2_valid;
  logic [DW-1:0] out2_data;
  logic          out2_ready;

  modport slave (
    input  in_valid, in_data, in_s0, in_s1,
    input  out0_ready, out1_ready, out2_ready,
    output in_ready,
    output out0_valid, out0_data,
    output out1_valid, out1_data,
    output out2_valid, out2_data
  );

  modport master (
    output in_valid, in_data, in_s0, in_s1,
    output out0_ready, out1_ready, out2_ready,
    input  in_ready,
    input  out0_valid, out0_data,
    input  out1_valid, out1_data,
    input  out2_valid, out2_data
  );
endinterface

// File: rtl/oh_stream_demux3.sv
// 1-to-3 valid/ready demux; each channel owns a 2-entry head/tail buffer so a
// stalled consumer only blocks words routed to its own channel.
module oh_stream_demux3_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic          o_full,
  output logic [DW-1:0] o_data
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

  cnt_e          r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic          w_pop;

  assign w_pop = (r_cnt != EMPTY) & i_ready;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case (r_cnt)
      EMPTY: if (i_push) begin
        w_cnt_nxt  = ONE;
        w_head_nxt = i_data;
      end
      ONE: begin
        // push+pop keeps one word: the new word becomes head directly
        if (i_push && w_pop) begin
          w_head_nxt = i_data;
        end else if (i_push) begin
          w_tail_nxt = i_data;
          w_cnt_nxt  = FULL;
        end else if (w_pop) begin
          w_cnt_nxt  = EMPTY;
        end
      end
      FULL: if (w_pop) begin
        w_head_nxt = r_tail;
        w_cnt_nxt  = ONE;
      end
      default: w_cnt_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_nxt;
      r_tail <= w_tail_nxt;
    end
  end

  assign o_valid = (r_cnt != EMPTY);
  assign o_full  = (r_cnt == FULL);
  assign o_data  = r_head;
endmodule

module oh_stream_demux3 #(
  parameter int DW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input logic              clk,
  input logic              nreset,
  oh_stream_demux3_if.slave bus
);
  logic [1:0]          w_sel;
  logic [2:0]          w_push, w_rdy, w_valid, w_full;
  logic [2:0][DW-1:0]  w_data;
  logic                w_in_ready;

  // PROP is a pass-through tag for the implementation flow; no RTL depends on it
  if (PROP == "") begin : g_prop_empty
  end

  assign w_sel = bus.in_s1 ? 2'd2 : (bus.in_s0 ? 2'd1 : 2'd0);

  // Ready comes only from registered occupancy and the select, never from outN_ready
  always_comb begin
    w_in_ready = 1'b1;
    case (w_sel)
      2'd0:    w_in_ready = ~w_full[0];
      2'd1:    w_in_ready = ~w_full[1];
      2'd2:    w_in_ready = ~w_full[2];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign w_rdy = {bus.out2_ready, bus.out1_ready, bus.out0_ready};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    assign w_push[g] = bus.in_valid & w_in_ready & (w_sel == 2'(g));
    oh_stream_demux3_chan #(.DW(DW)) u_chan (
      .clk     (clk),
      .nreset  (nreset),
      .i_push  (w_push[g]),
      .i_data  (bus.in_data),
      .i_ready (w_rdy[g]),
      .o_valid (w_valid[g]),
      .o_full  (w_full[g]),
      .o_data  (w_data[g])
    );
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out0_valid = w_valid[0];
  assign bus.out1_valid = w_valid[1];
  assign bus.out2_valid = w_valid[2];
  assign bus.out0_data  = w_data[0];
  assign bus.out1_data  = w_data[1];
  assign bus.out2_data  = w_data[2];
endmodule
